// File: rtl/ads131_spi_word_shifter.sv
// SPI mode-1 word shifter for the ADS131A0X link: drives MOSI from a command word and
// assembles MISO into rx_word, using an oversampled SCLK from the local SCLK generator.
module ads131_spi_word_shifter #(
  parameter int WORD_BITS = 16
) (
  input  logic                 system_clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WORD_BITS-1:0] tx_word,
  input  logic                 frame_active,
  input  logic                 spi_sclk,
  input  logic                 spi_miso,
  output logic                 spi_mosi,
  output logic [WORD_BITS-1:0] rx_word,
  output logic                 rx_valid,
  output logic                 busy,
  output logic                 frame_error
);

  localparam int CW = $clog2(WORD_BITS + 1);

  typedef enum logic [1:0] {IDLE, ARMED, SHIFT, DONE} state_t;

  state_t               state_reg;
  logic                 sclk_s1_reg, sclk_s2_reg, sclk_s3_reg;
  logic                 miso_m1_reg, miso_m2_reg;
  logic [WORD_BITS-1:0] tx_shift_reg;
  logic [WORD_BITS-1:0] rx_shift_reg;
  logic [CW-1:0]        bit_count_reg;

  logic                 sclk_rise, sclk_fall, last_fall;
  logic [WORD_BITS-1:0] rx_shift_next;

  // s2/s3 form the edge detector; m2 is captured alongside s2 so it lines up with the fall.
  assign sclk_rise     = sclk_s2_reg & ~sclk_s3_reg;
  assign sclk_fall     = ~sclk_s2_reg & sclk_s3_reg;
  assign rx_shift_next = {rx_shift_reg[WORD_BITS-2:0], miso_m2_reg};
  assign last_fall     = sclk_fall && (bit_count_reg == CW'(WORD_BITS - 1));

  always_ff @(posedge system_clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      sclk_s1_reg   <= 1'b0;
      sclk_s2_reg   <= 1'b0;
      sclk_s3_reg   <= 1'b0;
      miso_m1_reg   <= 1'b0;
      miso_m2_reg   <= 1'b0;
      tx_shift_reg  <= '0;
      rx_shift_reg  <= '0;
      bit_count_reg <= '0;
      spi_mosi      <= 1'b0;
      rx_word       <= '0;
      rx_valid      <= 1'b0;
      busy          <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      sclk_s1_reg <= spi_sclk;
      sclk_s2_reg <= sclk_s1_reg;
      sclk_s3_reg <= sclk_s2_reg;
      miso_m1_reg <= spi_miso;
      miso_m2_reg <= miso_m1_reg;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;

      case (state_reg)
        IDLE: begin
          spi_mosi <= 1'b0;
          if (start) begin
            tx_shift_reg  <= tx_word;
            rx_shift_reg  <= '0;
            bit_count_reg <= '0;
            busy          <= 1'b1;
            state_reg     <= ARMED;
          end
        end
        ARMED: begin
          if (frame_active) state_reg <= SHIFT;
        end
        SHIFT: begin
          // The completing fall outranks a simultaneous drop of frame_active.
          if (last_fall) begin
            rx_shift_reg  <= rx_shift_next;
            rx_word       <= rx_shift_next;
            rx_valid      <= 1'b1;
            bit_count_reg <= bit_count_reg + CW'(1);
            spi_mosi      <= 1'b0;
            state_reg     <= DONE;
          end else if (!frame_active) begin
            frame_error <= 1'b1;
            spi_mosi    <= 1'b0;
            busy        <= 1'b0;
            state_reg   <= IDLE;
          end else begin
            if (sclk_rise) begin
              spi_mosi     <= tx_shift_reg[WORD_BITS-1];
              tx_shift_reg <= {tx_shift_reg[WORD_BITS-2:0], 1'b0};
            end
            if (sclk_fall) begin
              rx_shift_reg  <= rx_shift_next;
              bit_count_reg <= bit_count_reg + CW'(1);
            end
          end
        end
        DONE: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ads131_spi_word_shifter.sv
// Bench for ads131_spi_word_shifter: drives SCLK frames with loopback or an ADC-style
// MISO source and compares against words and timing derived from SPI mode-1 rules.
module tb_ads131_spi_word_shifter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] tx_word;
  logic        frame_active;
  logic        spi_sclk;
  logic        spi_miso;
  logic        spi_mosi;
  logic [15:0] rx_word;
  logic        rx_valid;
  logic        busy;
  logic        frame_error;

  logic        loopback = 1'b1;
  logic        adc_bit = 1'b0;
  logic [15:0] adc_word = '0;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int valid_cyc = 0;
  int err_cnt = 0;
  int last_fall_cyc = 0;
  bit mosi_q[$];

  assign spi_miso = loopback ? spi_mosi : adc_bit;

  ads131_spi_word_shifter #(.WORD_BITS(16)) dut (
    .system_clock(clk),
    .reset(reset),
    .start(start),
    .tx_word(tx_word),
    .frame_active(frame_active),
    .spi_sclk(spi_sclk),
    .spi_miso(spi_miso),
    .spi_mosi(spi_mosi),
    .rx_word(rx_word),
    .rx_valid(rx_valid),
    .busy(busy),
    .frame_error(frame_error)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      valid_cyc = cyc;
    end
    if (frame_error) err_cnt++;
  end

  task automatic pulse_start(input logic [15:0] w);
    @(posedge clk); #1;
    tx_word = w;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Full SCLK periods; the ADC model updates DOUT on rising edges, MOSI is recorded at each fall.
  task automatic sclk_cycles(input int n, input int half, input bit drop_last);
    for (int i = 0; i < n; i++) begin
      repeat (half) @(posedge clk); #1;
      spi_sclk = 1'b1;
      if (i < 16) adc_bit = adc_word[15-i];
      repeat (half) @(posedge clk); #1;
      spi_sclk = 1'b0;
      mosi_q.push_back(spi_mosi);
      last_fall_cyc = cyc;
      if (drop_last && i == n - 1) begin
        repeat (2) @(posedge clk); #1;
        frame_active = 1'b0;
      end
    end
  endtask

  task automatic settle();
    repeat (8) @(posedge clk);
    #2;
  endtask

  task automatic run_frame(input logic [15:0] w, input bit lb, input logic [15:0] aw,
                           input int half, input bit drop_last);
    loopback = lb;
    adc_word = aw;
    mosi_q.delete();
    pulse_start(w);
    frame_active = 1'b1;
    sclk_cycles(16, half, drop_last);
    settle();
    frame_active = 1'b0;
    $display("frame tx=%h src=%s rx_word=%h half=%0d", w, lb ? "loop" : "adc", rx_word, half);
  endtask

  function automatic logic [15:0] mosi_word();
    logic [15:0] r = '0;
    foreach (mosi_q[i]) if (i < 16) r[15-i] = mosi_q[i];
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    frame_active = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    compared++; if (spi_mosi !== 1'b0) begin mismatched++; $display("FAIL reset_mosi: got %b want 0", spi_mosi); end
    compared++; if (rx_word !== 16'h0) begin mismatched++; $display("FAIL reset_rx_word: got %h want 0000", rx_word); end
    compared++; if (rx_valid !== 1'b0) begin mismatched++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
    compared++; if (frame_error !== 1'b0) begin mismatched++; $display("FAIL reset_frame_error: got %b want 0", frame_error); end
    reset = 1'b0;
    frame_active = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_loopback();
    int v0 = valid_cnt;
    int e0 = err_cnt;
    run_frame(16'h0655, 1'b1, 16'h0, 4, 1'b0);
    compared++; if (rx_word !== 16'h0655) begin mismatched++; $display("FAIL loop_rx_word: got %h want 0655", rx_word); end
    compared++; if (valid_cnt - v0 !== 1) begin mismatched++; $display("FAIL loop_valid_count: got %0d want 1", valid_cnt - v0); end
    compared++; if (valid_cyc - last_fall_cyc !== 3) begin mismatched++; $display("FAIL loop_latency: got %0d want 3", valid_cyc - last_fall_cyc); end
    compared++; if (err_cnt - e0 !== 0) begin mismatched++; $display("FAIL loop_error: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_adc_status();
    int v0 = valid_cnt;
    int e0 = err_cnt;
    run_frame(16'h0555, 1'b0, 16'hFF04, 4, 1'b0);
    compared++; if (rx_word !== 16'hFF04) begin mismatched++; $display("FAIL adc_rx_word: got %h want ff04", rx_word); end
    compared++; if (valid_cnt - v0 !== 1) begin mismatched++; $display("FAIL adc_valid_count: got %0d want 1", valid_cnt - v0); end
    compared++; if (err_cnt - e0 !== 0) begin mismatched++; $display("FAIL adc_error: got %0d want 0", err_cnt - e0); end
    compared++; if (mosi_word() !== 16'h0555) begin mismatched++; $display("FAIL adc_mosi_bits: got %h want 0555", mosi_word()); end
  endtask

  task automatic test_abort();
    int v0 = valid_cnt;
    int e0 = err_cnt;
    bit seen = 0;
    loopback = 1'b0;
    adc_word = 16'hA5C3;
    pulse_start(16'h3C3C);
    frame_active = 1'b1;
    sclk_cycles(8, 4, 1'b0);
    repeat (4) @(posedge clk); #1;
    frame_active = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (frame_error) begin
        seen = 1;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL abort_busy: got %b want 0", busy); end
        @(negedge clk);
        compared++; if (frame_error !== 1'b0) begin mismatched++; $display("FAIL abort_pulse_width: got %b want 0", frame_error); end
      end
    end
    compared++; if (!seen) begin mismatched++; $display("FAIL abort_timeout: got no frame_error want pulse"); end
    settle();
    $display("abort after 8 falls rx_word=%h", rx_word);
    compared++; if (err_cnt - e0 !== 1) begin mismatched++; $display("FAIL abort_error_count: got %0d want 1", err_cnt - e0); end
    compared++; if (valid_cnt - v0 !== 0) begin mismatched++; $display("FAIL abort_valid_count: got %0d want 0", valid_cnt - v0); end
    compared++; if (rx_word !== 16'hFF04) begin mismatched++; $display("FAIL abort_rx_word: got %h want ff04", rx_word); end
  endtask

  task automatic test_reset_mid_frame();
    int e0 = err_cnt;
    int v0;
    loopback = 1'b1;
    pulse_start(16'h0655);
    frame_active = 1'b1;
    sclk_cycles(5, 4, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    $display("reset after 5 falls busy=%b rx_word=%h", busy, rx_word);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    compared++; if (rx_word !== 16'h0) begin mismatched++; $display("FAIL rst_mid_rx_word: got %h want 0000", rx_word); end
    compared++; if (spi_mosi !== 1'b0) begin mismatched++; $display("FAIL rst_mid_mosi: got %b want 0", spi_mosi); end
    reset = 1'b0;
    frame_active = 1'b0;
    settle();
    compared++; if (err_cnt - e0 !== 0) begin mismatched++; $display("FAIL rst_mid_error: got %0d want 0", err_cnt - e0); end
    v0 = valid_cnt;
    run_frame(16'h0655, 1'b1, 16'h0, 4, 1'b0);
    compared++; if (rx_word !== 16'h0655) begin mismatched++; $display("FAIL rst_next_rx_word: got %h want 0655", rx_word); end
    compared++; if (valid_cnt - v0 !== 1) begin mismatched++; $display("FAIL rst_next_valid: got %0d want 1", valid_cnt - v0); end
  endtask

  task automatic test_ignored_inputs();
    logic [15:0] w = 16'(($urandom & 16'hFFFF) | 16'h8001);
    int v0 = valid_cnt;
    loopback = 1'b1;
    mosi_q.delete();
    pulse_start(w);
    pulse_start(16'h1234);
    frame_active = 1'b1;
    sclk_cycles(4, 4, 1'b0);
    pulse_start(16'h1234);
    sclk_cycles(12, 4, 1'b0);
    settle();
    frame_active = 1'b0;
    $display("frame tx=%h with stray starts rx_word=%h", w, rx_word);
    compared++; if (rx_word !== w) begin mismatched++; $display("FAIL ign_start_rx_word: got %h want %h", rx_word, w); end
    compared++; if (mosi_word() !== w) begin mismatched++; $display("FAIL ign_start_mosi: got %h want %h", mosi_word(), w); end
    v0 = valid_cnt;
    frame_active = 1'b1;
    sclk_cycles(2, 4, 1'b0);
    settle();
    frame_active = 1'b0;
    compared++; if (valid_cnt - v0 !== 0) begin mismatched++; $display("FAIL extra_sclk_valid: got %0d want 0", valid_cnt - v0); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL extra_sclk_busy: got %b want 0", busy); end
  endtask

  task automatic test_simultaneous();
    int v0 = valid_cnt;
    int e0 = err_cnt;
    run_frame(16'hC0DE, 1'b0, 16'h5AA5, 4, 1'b1);
    compared++; if (valid_cnt - v0 !== 1) begin mismatched++; $display("FAIL simul_valid: got %0d want 1", valid_cnt - v0); end
    compared++; if (err_cnt - e0 !== 0) begin mismatched++; $display("FAIL simul_error: got %0d want 0", err_cnt - e0); end
    compared++; if (rx_word !== 16'h5AA5) begin mismatched++; $display("FAIL simul_rx_word: got %h want 5aa5", rx_word); end
  endtask

  task automatic test_back_to_back();
    bit seen = 0;
    logic [15:0] w2 = 16'($urandom);
    loopback = 1'b1;
    mosi_q.delete();
    pulse_start(16'h1357);
    frame_active = 1'b1;
    sclk_cycles(16, 4, 1'b0);
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (rx_valid) seen = 1;
    end
    compared++; if (!seen) begin mismatched++; $display("FAIL b2b_timeout: got no rx_valid want pulse"); end
    compared++; if (rx_word !== 16'h1357) begin mismatched++; $display("FAIL b2b_first_word: got %h want 1357", rx_word); end
    @(posedge clk); #1;
    tx_word = w2;
    start = 1'b1;
    @(negedge clk);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL b2b_busy_idle: got %b want 0", busy); end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL b2b_start_accept: got %b want 1", busy); end
    mosi_q.delete();
    sclk_cycles(16, 4, 1'b0);
    settle();
    frame_active = 1'b0;
    $display("back-to-back tx=1357 then %h rx_word=%h", w2, rx_word);
    compared++; if (rx_word !== w2) begin mismatched++; $display("FAIL b2b_second_word: got %h want %h", rx_word, w2); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      logic [15:0] w = 16'($urandom);
      logic [15:0] aw = 16'($urandom);
      bit lb = 1'($urandom_range(0, 1));
      int half = int'($urandom_range(4, 6));
      logic [15:0] exp_rx = lb ? w : aw;
      int v0 = valid_cnt;
      run_frame(w, lb, aw, half, 1'b0);
      compared++; if (rx_word !== exp_rx) begin mismatched++; $display("FAIL rand_rx_word[%0d]: got %h want %h", n, rx_word, exp_rx); end
      compared++; if (mosi_word() !== w) begin mismatched++; $display("FAIL rand_mosi[%0d]: got %h want %h", n, mosi_word(), w); end
      compared++; if (valid_cnt - v0 !== 1) begin mismatched++; $display("FAIL rand_valid[%0d]: got %0d want 1", n, valid_cnt - v0); end
    end
  endtask

  initial begin
    start = 1'b0;
    tx_word = '0;
    frame_active = 1'b0;
    spi_sclk = 1'b0;
    reset = 1'b1;
    test_reset();
    test_loopback();
    test_adc_status();
    test_abort();
    test_reset_mid_frame();
    test_ignored_inputs();
    test_simultaneous();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ads131_spi_word_shifter.md
# ads131_spi_word_shifter

Data path stage directly downstream of the SPI SCLK generator on the ADS131A0X interface. It watches the generated SPI_SCLK and shifts a command word out on MOSI (updated after rising edges). It captures the ADC's DOUT on falling edges (SPI mode 1, CPOL=0, CPHA=1). It then hands the assembled word to the transaction controller with a one-cycle valid pulse. Everything runs in the system_clock domain; SCLK is treated as a sampled data signal.

## Interface
- WORD_BITS, 16, bits per word (16/24/32; the SCLK generator currently delivers 16 SCLK cycles per frame)
- system_clock  in  1  50 MHz system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: load tx_word and arm a frame; accepted only in IDLE
- tx_word  in  WORD_BITS  command word, MSB first; sampled only when start is accepted
- frame_active  in  1  high while the controller holds the transaction state (CS asserted)
- spi_sclk  in  1  SPI_SCLK from the SCLK generator
- spi_miso  in  1  ADC DOUT, asynchronous to system_clock
- spi_mosi  out  1  ADC DIN
- rx_word  out  WORD_BITS  last completed received word
- rx_valid  out  1  one-cycle pulse when rx_word is updated
- busy  out  1  high in every state except IDLE
- frame_error  out  1  one-cycle pulse when a frame is aborted

## Operation
- Synchronizers:
  - spi_sclk goes through three flops, s1→s2→s3; rise = s2 & ~s3, fall = ~s2 & s3.
  - spi_miso goes through two flops, m1→m2; m2 is the sampled bit, aligned with s2.
- The FSM has four states.
  - IDLE: start loads the tx shift register with tx_word, clears bit_count, and moves to ARMED. SCLK edges are ignored.
  - ARMED: waits for frame_active=1, then moves to SHIFT. SCLK edges and start are ignored.
  - SHIFT:
    - On rise: spi_mosi <= tx_shift[MSB], then tx_shift <<= 1 (zero fill).
    - On fall: rx_shift <= {rx_shift[WORD_BITS-2:0], m2} and bit_count+1.
    - When a fall makes bit_count == WORD_BITS: rx_word <= the new rx_shift value, rx_valid <= 1, state <= DONE.
  - DONE: lasts one cycle, then returns to IDLE. start is ignored here.
- bit_count is $clog2(WORD_BITS+1) bits wide and never wraps; edges after the final bit are ignored.
- Abort: frame_active=0 in SHIFT with bit_count < WORD_BITS gives a frame_error pulse and a return to IDLE. rx_word holds its previous value and rx_valid stays low.
- Simultaneous events:
  - The completing fall and frame_active dropping in the same cycle: completion wins; no frame_error.
  - start in any state other than IDLE is dropped silently.
- spi_mosi is driven low in IDLE, ARMED and DONE.
- Reset values: spi_mosi=0, rx_word=0, rx_valid=0, busy=0, frame_error=0, state IDLE. All synchronizer flops clear to 0.
- Reset mid-frame returns to IDLE on the next edge and discards the partial word; no error pulse.

## Timing
- Edge detect latency: spi_sclk changes after system_clock edge P0. The detect is combinational in the cycle after P2, and its register effects land at P3.
  - spi_mosi updates at P3 after an SCLK rise.
  - rx_valid/rx_word update at P3 after the last SCLK fall.
- Constraint: the SCLK half-period must be at least 4 system_clock cycles, so MOSI is stable before the ADC samples on the falling edge.
- rx_valid and frame_error are exactly one cycle wide. busy drops the cycle after DONE.
- Back-to-back frames: the earliest next start is accepted in the first IDLE cycle after DONE.

## Test plan
- Loopback: spi_miso tied to spi_mosi, start with tx_word=0x0655, frame_active high, 16 SCLK cycles at half-period 4 -> exactly one rx_valid pulse with rx_word=0x0655, 3 cycles after the 16th falling edge.
- ADC status: a MISO model shifts 0xFF04 on SCLK rising edges -> rx_word=0xFF04, rx_valid once, no frame_error. Verify MOSI bits at each falling edge equal tx_word=0x0555 MSB-first.
- Abort: frame_active drops after 8 falling edges -> one frame_error pulse, no rx_valid, rx_word still 0xFF04 from the prior frame, busy=0 next cycle.
- Reset mid-frame: assert reset after 5 falling edges -> all outputs at reset values next cycle. The next full frame with 0x0655 then completes correctly.
- Ignored inputs:
  - start pulsed in ARMED and SHIFT with 0x1234 -> frame still shifts the original tx_word.
  - 2 extra SCLK cycles after DONE -> no state change and no second rx_valid.
- Simultaneous: frame_active falls in the same cycle as the 16th fall detect -> rx_valid=1 and frame_error=0.
